// File: rtl/motor_ramp_controller.sv
// Slew-limited 10-bit motor command sequencer: ramps cmd toward the clamped target once per
// update tick, ramps down on brake/disable, and latches overcurrent faults with cmd forced to 0.
`timescale 1ns/1ps
module motor_ramp_controller #(
  parameter int pTickDiv   = 50000,
  parameter int pStep      = 4,
  parameter int pBrakeStep = 16,
  parameter int pMaxCmd    = 511
) (
  input  logic       RAMPclock,
  input  logic       RAMPreset_n,
  input  logic       enable,
  input  logic       brake,
  input  logic       fault,
  input  logic       fault_clear,
  input  logic [9:0] target,
  output logic [9:0] cmd,
  output logic       cmd_update,
  output logic [1:0] state,
  output logic       at_target
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, BRAKE = 2'd2, FAULT = 2'd3} state_t;

  localparam logic [15:0]        kTickLast  = 16'(pTickDiv - 1);
  localparam logic signed [9:0]  kMaxCmd    = 10'(pMaxCmd);
  localparam logic signed [9:0]  kMinCmd    = 10'(-pMaxCmd);
  localparam logic signed [9:0]  kStepN     = 10'(pStep);
  localparam logic signed [9:0]  kBrakeN    = 10'(pBrakeStep);
  localparam logic signed [10:0] kStepW     = 11'(pStep);
  localparam logic signed [10:0] kBrakeW    = 11'(pBrakeStep);

  logic [15:0]        tickCount;
  logic               tick;
  logic signed [9:0]  targetReg;
  logic signed [9:0]  tgt;
  logic signed [9:0]  cmdReg;
  logic signed [9:0]  cmdNext;
  logic signed [9:0]  runCmd;
  logic signed [9:0]  brakeCmd;
  logic signed [10:0] cmdWide;
  logic signed [10:0] tgtWide;
  logic signed [10:0] diff;
  logic signed [10:0] absDiff;
  logic signed [10:0] absCmd;
  logic               crossing;
  logic               cmdUpdate;
  logic               atTarget;
  state_t             stateReg;
  state_t             stateNext;

  function automatic logic signed [9:0] clampTarget(input logic signed [9:0] raw);
    logic signed [9:0] res;
    res = raw;
    if (raw > kMaxCmd)
      res = kMaxCmd;
    else if (raw < kMinCmd)
      res = kMinCmd;
    return res;
  endfunction

  assign tick = (tickCount == kTickLast);
  assign tgt  = clampTarget(targetReg);

  // Candidate next commands for the RUN and BRAKE slews; zero is always visited before a sign change.
  always_comb begin
    cmdWide  = {cmdReg[9], cmdReg};
    tgtWide  = {tgt[9], tgt};
    diff     = tgtWide - cmdWide;
    absDiff  = diff[10] ? -diff : diff;
    absCmd   = cmdWide[10] ? -cmdWide : cmdWide;
    crossing = (cmdReg != '0) && (tgt != '0) && (cmdReg[9] != tgt[9]);

    runCmd = cmdReg;
    if (crossing && (absCmd <= kStepW))
      runCmd = '0;
    else if (absDiff <= kStepW)
      runCmd = tgt;
    else if (diff[10])
      runCmd = cmdReg - kStepN;
    else
      runCmd = cmdReg + kStepN;

    brakeCmd = cmdReg;
    if (absCmd <= kBrakeW)
      brakeCmd = '0;
    else if (cmdWide[10])
      brakeCmd = cmdReg + kBrakeN;
    else
      brakeCmd = cmdReg - kBrakeN;
  end

  always_comb begin
    stateNext = stateReg;
    cmdNext   = cmdReg;
    if (fault) begin
      stateNext = FAULT;
      cmdNext   = '0;
    end else begin
      case (stateReg)
        IDLE: begin
          cmdNext = '0;
          if (enable && !brake)
            stateNext = RUN;
        end
        RUN: begin
          if (brake || !enable)
            stateNext = BRAKE;
          else if (tick)
            cmdNext = runCmd;
        end
        BRAKE: begin
          if (cmdReg == '0)
            stateNext = IDLE;
          else if (tick)
            cmdNext = brakeCmd;
        end
        FAULT: begin
          cmdNext = '0;
          if (fault_clear)
            stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // at_target is computed from next-cycle values so it lines up with the registered cmd and target.
  always_ff @(posedge RAMPclock) begin
    if (!RAMPreset_n) begin
      tickCount <= '0;
      targetReg <= '0;
      cmdReg    <= '0;
      stateReg  <= IDLE;
      cmdUpdate <= 1'b0;
      atTarget  <= 1'b0;
    end else begin
      tickCount <= tick ? '0 : tickCount + 16'd1;
      targetReg <= target;
      cmdReg    <= cmdNext;
      stateReg  <= stateNext;
      cmdUpdate <= (cmdNext != cmdReg);
      atTarget  <= (stateNext == RUN) && (cmdNext == clampTarget(target));
    end
  end

  assign cmd        = cmdReg;
  assign cmd_update = cmdUpdate;
  assign state      = stateReg;
  assign at_target  = atTarget;

endmodule

// File: tb/tb_motor_ramp_controller.sv
// Bench for motor_ramp_controller: directed scenarios plus random stimulus, all checked
// against an integer cycle model of the ramp rules.
`timescale 1ns/1ps
module tb_motor_ramp_controller;

  localparam int TD    = 4;
  localparam int STEP  = 4;
  localparam int BSTEP = 16;
  localparam int MAXC  = 511;

  logic       RAMPclock = 1'b0;
  logic       RAMPreset_n;
  logic       enable;
  logic       brake;
  logic       fault;
  logic       fault_clear;
  logic [9:0] target;
  logic [9:0] cmd;
  logic       cmd_update;
  logic [1:0] state;
  logic       at_target;

  int vectors = 0;
  int miscompares = 0;

  int mCount = 0;
  int mTargetRaw = 0;
  int mCmd = 0;
  int mState = 0;
  bit mUpd = 1'b0;
  bit mAt = 1'b0;

  always #5 RAMPclock = ~RAMPclock;

  motor_ramp_controller #(
    .pTickDiv(TD), .pStep(STEP), .pBrakeStep(BSTEP), .pMaxCmd(MAXC)
  ) dut (
    .RAMPclock(RAMPclock),
    .RAMPreset_n(RAMPreset_n),
    .enable(enable),
    .brake(brake),
    .fault(fault),
    .fault_clear(fault_clear),
    .target(target),
    .cmd(cmd),
    .cmd_update(cmd_update),
    .state(state),
    .at_target(at_target)
  );

  function automatic int clampInt(input int v);
    if (v > MAXC) return MAXC;
    if (v < -MAXC) return -MAXC;
    return v;
  endfunction

  function automatic int absInt(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int toInt10(input logic [9:0] v);
    return int'($signed(v));
  endfunction

  // Reference model: plain integer arithmetic on the ramp rules, advanced once per rising edge.
  always @(posedge RAMPclock) begin : refModel
    int  tgt;
    int  nextCmd;
    int  nextState;
    int  move;
    bit  tickNow;
    if (RAMPreset_n !== 1'b1) begin
      mCount = 0; mTargetRaw = 0; mCmd = 0; mState = 0; mUpd = 1'b0; mAt = 1'b0;
    end else begin
      tickNow   = (mCount == TD - 1);
      tgt       = clampInt(mTargetRaw);
      nextCmd   = mCmd;
      nextState = mState;
      if (fault === 1'b1) begin
        nextState = 3;
        nextCmd   = 0;
      end else if (mState == 0) begin
        if (enable && !brake) nextState = 1;
      end else if (mState == 1) begin
        if (brake || !enable) nextState = 2;
        else if (tickNow) begin
          if ((mCmd * tgt < 0) && (absInt(mCmd) <= STEP)) nextCmd = 0;
          else begin
            move = tgt - mCmd;
            if (move > STEP) move = STEP;
            if (move < -STEP) move = -STEP;
            nextCmd = mCmd + move;
          end
        end
      end else if (mState == 2) begin
        if (mCmd == 0) nextState = 0;
        else if (tickNow) nextCmd = (absInt(mCmd) <= BSTEP) ? 0 : ((mCmd > 0) ? mCmd - BSTEP : mCmd + BSTEP);
      end else begin
        if (fault_clear) nextState = 0;
      end
      mUpd       = (nextCmd != mCmd);
      mCount     = tickNow ? 0 : mCount + 1;
      mTargetRaw = toInt10(target);
      mAt        = (nextState == 1) && (nextCmd == clampInt(mTargetRaw));
      mCmd       = nextCmd;
      mState     = nextState;
    end
  end

  task automatic step();
    @(posedge RAMPclock);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic brk, input logic flt, input logic clr, input int tgtVal);
    enable      = en;
    brake       = brk;
    fault       = flt;
    fault_clear = clr;
    target      = 10'(tgtVal);
  endtask

  task automatic test_reset();
    RAMPreset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0);
    repeat (2) begin
      step();
      vectors++;
      if ({cmd, state, cmd_update, at_target} !== 14'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_values: cmd=%0d state=%0d upd=%0b at=%0b, expected all 0", $signed(cmd), state, cmd_update, at_target);
      end
    end
    RAMPreset_n = 1'b1;
  endtask

  task automatic test_ramp_up();
    int seen[$];
    int changeCyc[$];
    int expUp[5] = '{4, 8, 12, 16, 20};
    int lastCmd = 0;
    int pulses = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 20);
    for (int c = 0; c < 40; c++) begin
      step();
      vectors++;
      if (cmd !== 10'(mCmd) || state !== 2'(mState) || cmd_update !== mUpd || at_target !== mAt) begin
        miscompares++;
        $display("[TB] FAIL ramp_up_model c=%0d: cmd=%0d/%0d state=%0d/%0d upd=%0b/%0b at=%0b/%0b (got/exp)", c, $signed(cmd), mCmd, state, mState, cmd_update, mUpd, at_target, mAt);
      end
      if (cmd_update === 1'b1) pulses++;
      if (toInt10(cmd) != lastCmd) begin
        lastCmd = toInt10(cmd);
        seen.push_back(lastCmd);
        changeCyc.push_back(c);
      end
    end
    vectors++;
    if (seen.size() != 5 || pulses != 5) begin
      miscompares++;
      $display("[TB] FAIL ramp_up_steps: %0d steps and %0d pulses, expected 5 and 5", seen.size(), pulses);
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (seen[i] != expUp[i]) begin
          miscompares++;
          $display("[TB] FAIL ramp_up_value[%0d]: got %0d, expected %0d", i, seen[i], expUp[i]);
        end
      end
      for (int i = 1; i < 5; i++) begin
        vectors++;
        if (changeCyc[i] - changeCyc[i-1] != TD) begin
          miscompares++;
          $display("[TB] FAIL ramp_up_spacing[%0d]: %0d cycles, expected %0d", i, changeCyc[i] - changeCyc[i-1], TD);
        end
      end
    end
    repeat (8) begin
      step();
      vectors++;
      if (at_target !== 1'b1 || toInt10(cmd) != 20 || state !== 2'd1) begin
        miscompares++;
        $display("[TB] FAIL ramp_up_hold: at=%0b cmd=%0d state=%0d, expected 1, 20, 1", at_target, $signed(cmd), state);
      end
    end
  endtask

  task automatic test_zero_cross();
    int seen[$];
    int expSeq[5] = '{2, 0, -4, -8, -10};
    int lastCmd;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 6);
    for (int c = 0; c < 30; c++) begin
      step();
      vectors++;
      if (cmd !== 10'(mCmd) || state !== 2'(mState) || cmd_update !== mUpd || at_target !== mAt) begin
        miscompares++;
        $display("[TB] FAIL zero_cross_model c=%0d: cmd=%0d/%0d state=%0d/%0d upd=%0b/%0b at=%0b/%0b (got/exp)", c, $signed(cmd), mCmd, state, mState, cmd_update, mUpd, at_target, mAt);
      end
    end
    vectors++;
    if (toInt10(cmd) != 6) begin
      miscompares++;
      $display("[TB] FAIL zero_cross_start: cmd=%0d, expected 6", $signed(cmd));
    end
    lastCmd = toInt10(cmd);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, -10);
    for (int c = 0; c < 40; c++) begin
      step();
      vectors++;
      if (cmd !== 10'(mCmd) || state !== 2'(mState) || cmd_update !== mUpd || at_target !== mAt) begin
        miscompares++;
        $display("[TB] FAIL zero_cross_model2 c=%0d: cmd=%0d/%0d state=%0d/%0d upd=%0b/%0b at=%0b/%0b (got/exp)", c, $signed(cmd), mCmd, state, mState, cmd_update, mUpd, at_target, mAt);
      end
      if (toInt10(cmd) != lastCmd) begin
        vectors++;
        if (absInt(toInt10(cmd) - lastCmd) > STEP || (lastCmd > 0 && toInt10(cmd) < 0)) begin
          miscompares++;
          $display("[TB] FAIL zero_cross_jump: %0d -> %0d, expected step <= %0d without skipping 0", lastCmd, $signed(cmd), STEP);
        end
        lastCmd = toInt10(cmd);
        seen.push_back(lastCmd);
      end
    end
    vectors++;
    if (seen.size() != 5) begin
      miscompares++;
      $display("[TB] FAIL zero_cross_count: %0d steps, expected 5", seen.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (seen[i] != expSeq[i]) begin
          miscompares++;
          $display("[TB] FAIL zero_cross_value[%0d]: got %0d, expected %0d", i, seen[i], expSeq[i]);
        end
      end
    end
  endtask

  task automatic test_saturate();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, -512);
    for (int c = 0; c < 600; c++) begin
      step();
      vectors++;
      if (cmd !== 10'(mCmd) || state !== 2'(mState) || cmd_update !== mUpd || at_target !== mAt) begin
        miscompares++;
        $display("[TB] FAIL saturate_model c=%0d: cmd=%0d/%0d state=%0d/%0d upd=%0b/%0b at=%0b/%0b (got/exp)", c, $signed(cmd), mCmd, state, mState, cmd_update, mUpd, at_target, mAt);
      end
      vectors++;
      if (cmd === 10'h200) begin
        miscompares++;
        $display("[TB] FAIL saturate_range c=%0d: cmd=-512, expected >= -511", c);
      end
    end
    vectors++;
    if (toInt10(cmd) != -511 || at_target !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL saturate_final: cmd=%0d at=%0b, expected -511 and 1", $signed(cmd), at_target);
    end
  endtask

  task automatic test_brake();
    int seen[$];
    int expSeq[7] = '{84, 68, 52, 36, 20, 4, 0};
    int lastCmd;
    bit reached = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 100);
    for (int c = 0; c < 800 && !reached; c++) begin
      step();
      vectors++;
      if (cmd !== 10'(mCmd) || state !== 2'(mState) || cmd_update !== mUpd || at_target !== mAt) begin
        miscompares++;
        $display("[TB] FAIL brake_approach_model c=%0d: cmd=%0d/%0d state=%0d/%0d upd=%0b/%0b at=%0b/%0b (got/exp)", c, $signed(cmd), mCmd, state, mState, cmd_update, mUpd, at_target, mAt);
      end
      if (toInt10(cmd) == 100) reached = 1'b1;
    end
    vectors++;
    if (!reached) begin
      miscompares++;
      $display("[TB] FAIL brake_approach_timeout: cmd=%0d, expected 100 within 800 cycles", $signed(cmd));
    end
    step();
    lastCmd = toInt10(cmd);
    reached = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 100);
    for (int c = 0; c < 60 && !reached; c++) begin
      step();
      vectors++;
      if (cmd !== 10'(mCmd) || state !== 2'(mState) || cmd_update !== mUpd || at_target !== mAt) begin
        miscompares++;
        $display("[TB] FAIL brake_model c=%0d: cmd=%0d/%0d state=%0d/%0d upd=%0b/%0b at=%0b/%0b (got/exp)", c, $signed(cmd), mCmd, state, mState, cmd_update, mUpd, at_target, mAt);
      end
      if (toInt10(cmd) != lastCmd) begin
        lastCmd = toInt10(cmd);
        seen.push_back(lastCmd);
      end
      if (toInt10(cmd) == 0) reached = 1'b1;
    end
    vectors++;
    if (!reached || state !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL brake_at_zero: cmd=%0d state=%0d, expected 0 and 2", $signed(cmd), state);
    end
    vectors++;
    if (seen.size() != 7) begin
      miscompares++;
      $display("[TB] FAIL brake_count: %0d steps, expected 7", seen.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        vectors++;
        if (seen[i] != expSeq[i]) begin
          miscompares++;
          $display("[TB] FAIL brake_value[%0d]: got %0d, expected %0d", i, seen[i], expSeq[i]);
        end
      end
    end
    step();
    vectors++;
    if (state !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL brake_to_idle: state=%0d, expected 0", state);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 100);
    step();
    vectors++;
    if (state !== 2'd1 || cmd !== 10'd0) begin
      miscompares++;
      $display("[TB] FAIL brake_release: state=%0d cmd=%0d, expected 1 and 0", state, $signed(cmd));
    end
  endtask

  task automatic test_fault();
    bit reached = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 200);
    for (int c = 0; c < 300 && !reached; c++) begin
      step();
      vectors++;
      if (cmd !== 10'(mCmd) || state !== 2'(mState) || cmd_update !== mUpd || at_target !== mAt) begin
        miscompares++;
        $display("[TB] FAIL fault_approach_model c=%0d: cmd=%0d/%0d state=%0d/%0d upd=%0b/%0b at=%0b/%0b (got/exp)", c, $signed(cmd), mCmd, state, mState, cmd_update, mUpd, at_target, mAt);
      end
      if (toInt10(cmd) >= 120) reached = 1'b1;
    end
    vectors++;
    if (!reached) begin
      miscompares++;
      $display("[TB] FAIL fault_approach_timeout: cmd=%0d, expected >= 120 within 300 cycles", $signed(cmd));
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 200);
    step();
    vectors++;
    if (cmd !== 10'd0 || state !== 2'd3 || cmd_update !== 1'b1 || at_target !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL fault_entry: cmd=%0d state=%0d upd=%0b at=%0b, expected 0, 3, 1, 0", $signed(cmd), state, cmd_update, at_target);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 200);
    step();
    vectors++;
    if (state !== 2'd3 || cmd_update !== 1'b0 || cmd !== 10'd0) begin
      miscompares++;
      $display("[TB] FAIL fault_latched: state=%0d upd=%0b cmd=%0d, expected 3, 0, 0", state, cmd_update, $signed(cmd));
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 200);
    step();
    vectors++;
    if (state !== 2'd3) begin
      miscompares++;
      $display("[TB] FAIL fault_clear_blocked: state=%0d, expected 3", state);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 200);
    step();
    vectors++;
    if (state !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL fault_clear: state=%0d, expected 0", state);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 200);
    step();
    vectors++;
    if (state !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL fault_resume: state=%0d, expected 1", state);
    end
    reached = 1'b0;
    for (int c = 0; c < 20 && !reached; c++) begin
      step();
      if (cmd !== 10'd0) reached = 1'b1;
    end
    vectors++;
    if (toInt10(cmd) != STEP) begin
      miscompares++;
      $display("[TB] FAIL fault_resume_first_step: cmd=%0d, expected %0d", $signed(cmd), STEP);
    end
  endtask

  task automatic test_reset_midrun();
    bit reached = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 300);
    for (int c = 0; c < 500 && !reached; c++) begin
      step();
      vectors++;
      if (cmd !== 10'(mCmd) || state !== 2'(mState) || cmd_update !== mUpd || at_target !== mAt) begin
        miscompares++;
        $display("[TB] FAIL midrun_model c=%0d: cmd=%0d/%0d state=%0d/%0d upd=%0b/%0b at=%0b/%0b (got/exp)", c, $signed(cmd), mCmd, state, mState, cmd_update, mUpd, at_target, mAt);
      end
      if (toInt10(cmd) == 300) reached = 1'b1;
    end
    vectors++;
    if (!reached) begin
      miscompares++;
      $display("[TB] FAIL midrun_timeout: cmd=%0d, expected 300 within 500 cycles", $signed(cmd));
    end
    RAMPreset_n = 1'b0;
    step();
    vectors++;
    if ({cmd, state, cmd_update, at_target} !== 14'd0) begin
      miscompares++;
      $display("[TB] FAIL midrun_reset: cmd=%0d state=%0d upd=%0b at=%0b, expected all 0", $signed(cmd), state, cmd_update, at_target);
    end
    RAMPreset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 40);
    repeat (3) step();
    vectors++;
    if (state !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL midrun_rerun: state=%0d, expected 1", state);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 40);
    step();
    vectors++;
    if (state !== 2'd3 || cmd !== 10'd0) begin
      miscompares++;
      $display("[TB] FAIL fault_over_brake: state=%0d cmd=%0d, expected 3 and 0", state, $signed(cmd));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 40);
    step();
  endtask

  task automatic test_random();
    logic en = 1'b1;
    logic brk = 1'b0;
    int tval = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) en = ~en;
      if ($urandom_range(0, 39) == 0) brk = ~brk;
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 3))
          0:       tval = -512;
          1:       tval = 511;
          default: tval = int'($urandom_range(0, 1023)) - 512;
        endcase
      end
      RAMPreset_n = ($urandom_range(0, 499) != 0);
      applyStimulus(en, brk, $urandom_range(0, 79) == 0, $urandom_range(0, 7) == 0, tval);
      step();
      vectors++;
      if (cmd !== 10'(mCmd) || state !== 2'(mState) || cmd_update !== mUpd || at_target !== mAt) begin
        miscompares++;
        $display("[TB] FAIL random_model c=%0d: cmd=%0d/%0d state=%0d/%0d upd=%0b/%0b at=%0b/%0b (got/exp)", c, $signed(cmd), mCmd, state, mState, cmd_update, mUpd, at_target, mAt);
      end
      vectors++;
      if (cmd === 10'h200) begin
        miscompares++;
        $display("[TB] FAIL random_range c=%0d: cmd=-512, expected >= -511", c);
      end
    end
    RAMPreset_n = 1'b1;
  endtask

  initial begin
    $display("[TB] motor_ramp_controller bench start");
    test_reset();
    test_ramp_up();
    test_zero_cross();
    test_saturate();
    test_brake();
    test_fault();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
